// File: rtl/rrat_pkg.sv
// Shared sizing and types for the retirement register alias table.
package rrat_pkg;
    localparam int NUM_ARCH = 32;
    localparam int NUM_PHYS = 64;
    localparam int PREG_W   = 6;
    localparam int AREG_W   = 5;

    typedef logic [PREG_W-1:0] preg_t;
    typedef logic [AREG_W-1:0] areg_t;

    // Architectural r0 is hardwired; its map entry never changes.
    localparam areg_t ARCH_ZERO = '0;

    // One retirement slot as seen after the stall qualifier.
    typedef struct packed {
        logic  vld;
        logic  regwr;
        areg_t arch;
        preg_t phys;
    } retire_req_t;
endpackage

// File: rtl/rrat_check.sv
// Consistency checker: shadow "mapped" vector over physical tags plus a
// sticky error flag. Only instantiated when RRAT_CHECK_EN is defined.
module rrat_check
    import rrat_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic              wr,
    input  logic [AREG_W-1:0] arch,
    input  logic [PREG_W-1:0] phys,
    input  logic [PREG_W-1:0] map [NUM_ARCH],
    output logic              rrat_error
);
    logic [NUM_PHYS-1:0] mapped;
    preg_t               old_phys;
    logic                same;
    logic                dup_old;
    logic                bad;

    // Classify the retire: an install of a tag already live elsewhere, or a
    // free of a tag some other arch reg still points at, is an error.
    always_comb begin
        old_phys = map[arch];
        same     = (phys == old_phys);
        dup_old  = 1'b0;
        for (int i = 0; i < NUM_ARCH; i++)
            if (areg_t'(i) != arch && map[i] == old_phys) dup_old = 1'b1;
        bad = 1'b0;
        if (wr && !same) begin
            if (arch == ARCH_ZERO) bad = mapped[phys];
            else                   bad = mapped[phys] | dup_old;
        end
    end

    // Track live tags and latch the error until reset.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            mapped     <= {{(NUM_PHYS-NUM_ARCH){1'b0}}, {NUM_ARCH{1'b1}}};
            rrat_error <= 1'b0;
        end else begin
            if (wr && !same && arch != ARCH_ZERO) begin
                mapped[old_phys] <= 1'b0;
                mapped[phys]     <= 1'b1;
            end
            if (bad) rrat_error <= 1'b1;
        end
    end
endmodule

// File: rtl/rrat.sv
// Retirement register alias table: commits arch->phys mappings at retire,
// returns displaced tags to the free list, and drives FRAT restore on flush.
// Optional consistency checking is enabled by defining RRAT_CHECK_EN.
module rrat
    import rrat_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic              STALL,
    input  logic              FLUSH,
    input  logic              rob_retire,
    input  logic              rob_retire_regwr,
    input  logic [AREG_W-1:0] rob_retire_arch,
    input  logic [PREG_W-1:0] rob_retire_phys,
    output logic              rrat_free,
    output logic [PREG_W-1:0] rrat_free_reg,
    output logic [PREG_W-1:0] rrat_my_map [NUM_ARCH],
    output logic              frat_restore,
    output integer            retire_count,
    output logic              rrat_error
);
    retire_req_t req;
    preg_t       old_phys;
    preg_t       free_phys;
    logic        wr;
    logic        do_free;
    logic        flush_pend;

    // Decode the retire. r0 never takes a new mapping, so its allocated tag
    // is the one returned; retiring onto the current mapping is a no-op.
    always_comb begin
        req       = '{vld: rob_retire & ~STALL, regwr: rob_retire_regwr,
                      arch: rob_retire_arch, phys: rob_retire_phys};
        old_phys  = rrat_my_map[req.arch];
        wr        = req.vld & req.regwr;
        do_free   = wr & (req.phys != old_phys);
        free_phys = (req.arch == ARCH_ZERO) ? req.phys : old_phys;
    end

    // Committed map: identity at reset, updated on a changing retire.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < NUM_ARCH; i++) rrat_my_map[i] <= PREG_W'(i);
        end else if (do_free && req.arch != ARCH_ZERO) begin
            rrat_my_map[req.arch] <= req.phys;
        end
    end

    // Free-list pulse; the tag holds its last value between pulses.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rrat_free     <= 1'b0;
            rrat_free_reg <= '0;
        end else begin
            rrat_free <= do_free;
            if (do_free) rrat_free_reg <= free_phys;
        end
    end

    // Flush: restore pulse after the edge; a flush seen during stall waits
    // for the first unstalled edge so the map it restores is current.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            flush_pend   <= 1'b0;
            frat_restore <= 1'b0;
        end else if (STALL) begin
            frat_restore <= 1'b0;
            if (FLUSH) flush_pend <= 1'b1;
        end else begin
            frat_restore <= FLUSH | flush_pend;
            flush_pend   <= 1'b0;
        end
    end

    // Retired-instruction counter, frozen under stall.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)       retire_count <= 0;
        else if (req.vld) retire_count <= retire_count + 1;
    end

`ifdef RRAT_CHECK_EN
    rrat_check u_check (
        .CLK        (CLK),
        .RESET      (RESET),
        .wr         (wr),
        .arch       (req.arch),
        .phys       (req.phys),
        .map        (rrat_my_map),
        .rrat_error (rrat_error)
    );
`else
    assign rrat_error = 1'b0;
`endif
endmodule

// File: tb/tb_rrat.sv
// Scoreboard bench for rrat: stimulus pushes expected free tags and expected
// restore snapshots; a negedge monitor pops them as pulses appear.
module tb_rrat;
    import rrat_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        STALL, FLUSH;
    logic        rob_retire, rob_retire_regwr;
    logic [4:0]  rob_retire_arch;
    logic [5:0]  rob_retire_phys;
    logic        rrat_free;
    logic [5:0]  rrat_free_reg;
    logic [5:0]  rrat_my_map [NUM_ARCH];
    logic        frat_restore;
    integer      retire_count;
    logic        rrat_error;

    typedef struct { int arch; int phys; } snap_t;

    int    checks = 0;
    int    errors = 0;
    int    free_q[$];
    snap_t rest_q[$];

    rrat dut (
        .CLK(CLK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH),
        .rob_retire(rob_retire), .rob_retire_regwr(rob_retire_regwr),
        .rob_retire_arch(rob_retire_arch), .rob_retire_phys(rob_retire_phys),
        .rrat_free(rrat_free), .rrat_free_reg(rrat_free_reg),
        .rrat_my_map(rrat_my_map), .frat_restore(frat_restore),
        .retire_count(retire_count), .rrat_error(rrat_error)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (RESET === 1'b1 && rrat_free === 1'b1) begin
            if (free_q.size() == 0) chk("spurious_free", int'(rrat_free_reg), -1);
            else chk("free_reg", int'(rrat_free_reg), free_q.pop_front());
        end
        if (RESET === 1'b1 && frat_restore === 1'b1) begin
            if (rest_q.size() == 0) chk("spurious_restore", 1, 0);
            else begin
                snap_t s;
                s = rest_q.pop_front();
                chk("restore_map", int'(rrat_my_map[s.arch]), s.phys);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    // One retire cycle; exp_free < 0 means no free pulse is expected.
    task automatic retire(input int arch, input int phys, input bit regwr,
                          input int exp_free);
        rob_retire       = 1'b1;
        rob_retire_regwr = regwr;
        rob_retire_arch  = 5'(arch);
        rob_retire_phys  = 6'(phys);
        if (exp_free >= 0) free_q.push_back(exp_free);
        @(posedge CLK); #1;
        rob_retire       = 1'b0;
        rob_retire_regwr = 1'b0;
    endtask

    initial begin
        RESET = 1'b0; STALL = 1'b0; FLUSH = 1'b0;
        rob_retire = 1'b0; rob_retire_regwr = 1'b0;
        rob_retire_arch = '0; rob_retire_phys = '0;
        idle(2);
        for (int i = 0; i < NUM_ARCH; i++) chk("reset_map", int'(rrat_my_map[i]), i);
        chk("reset_free", int'(rrat_free), 0);
        chk("reset_free_reg", int'(rrat_free_reg), 0);
        chk("reset_restore", int'(frat_restore), 0);
        chk("reset_count", retire_count, 0);
        chk("reset_error", int'(rrat_error), 0);
        RESET = 1'b1;
        idle(1);

        // Basic retire.
        retire(5, 40, 1, 5);
        chk("map5", int'(rrat_my_map[5]), 40);
        chk("count1", retire_count, 1);
        idle(1);

        // r0 destination frees the allocated tag; non-writer frees nothing.
        retire(0, 33, 1, 33);
        chk("map0", int'(rrat_my_map[0]), 0);
        chk("count2", retire_count, 2);
        retire(9, 50, 0, -1);
        chk("map9_nowr", int'(rrat_my_map[9]), 9);
        chk("count3", retire_count, 3);
        idle(1);

        // Back-to-back retires.
        retire(3, 34, 1, 3);
        retire(3, 35, 1, 34);
        retire(7, 36, 1, 7);
        chk("map3", int'(rrat_my_map[3]), 35);
        chk("map7", int'(rrat_my_map[7]), 36);
        chk("count6", retire_count, 6);
        idle(2);

        // Stall with retire and flush pending for two edges.
        STALL = 1'b1; FLUSH = 1'b1;
        rob_retire = 1'b1; rob_retire_regwr = 1'b1;
        rob_retire_arch = 5'd10; rob_retire_phys = 6'd41;
        idle(2);
        chk("stall_map10", int'(rrat_my_map[10]), 10);
        chk("stall_count", retire_count, 6);
        STALL = 1'b0; FLUSH = 1'b0;
        free_q.push_back(10);
        rest_q.push_back('{arch: 10, phys: 41});
        @(posedge CLK); #1;
        rob_retire = 1'b0; rob_retire_regwr = 1'b0;
        chk("release_map10", int'(rrat_my_map[10]), 41);
        chk("release_count", retire_count, 7);
        idle(3);

        // Flush on the same edge as a retire: restore sees the new mapping.
        FLUSH = 1'b1;
        rest_q.push_back('{arch: 11, phys: 42});
        retire(11, 42, 1, 11);
        FLUSH = 1'b0;
        idle(1);

        // Retiring onto the current mapping: no change, no free.
        retire(11, 42, 1, -1);
        chk("same_map11", int'(rrat_my_map[11]), 42);
        chk("same_count", retire_count, 9);
        idle(1);

        // Duplicate install: tag 40 is already live at r5.
        retire(4, 40, 1, 4);
        chk("dup_map4", int'(rrat_my_map[4]), 40);
        idle(2);
`ifdef RRAT_CHECK_EN
        chk("error_set", int'(rrat_error), 1);
`else
        chk("error_tied", int'(rrat_error), 0);
`endif

        // Asynchronous reset mid-operation.
        RESET = 1'b0; #1;
        chk("async_map5", int'(rrat_my_map[5]), 5);
        chk("async_map4", int'(rrat_my_map[4]), 4);
        chk("async_count", retire_count, 0);
        chk("async_error", int'(rrat_error), 0);
        idle(1);
        RESET = 1'b1;
        idle(2);

        chk("free_q_drained", free_q.size(), 0);
        chk("rest_q_drained", rest_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rrat.md
# rrat

Retirement register alias table. Sits directly downstream of the reorder buffer and closes the rename loop: on each retired register-writing instruction it commits the architectural-to-physical mapping, returns the previous physical register to the rename stage's free list (`rrat_free` / `rrat_free_reg`), and supplies the committed map to the FRAT for recovery on flush.

## Interface
- `NUM_ARCH`, 32: architectural registers.
- `NUM_PHYS`, 64: physical registers; tag width `PREG_W` = 6.

- `CLK`  in  1  clock; all state updates on posedge.
- `RESET`  in  1  asynchronous, active-low reset.
- `STALL`  in  1  global stall; freezes block.
- `FLUSH`  in  1  pipeline flush request.
- `rob_retire`  in  1  ROB head retires this cycle.
- `rob_retire_regwr`  in  1  retiring instr writes a register (incl. loads).
- `rob_retire_arch`  in  5  architectural destination.
- `rob_retire_phys`  in  6  physical destination allocated at rename.
- `rrat_free`  out  1  one-cycle pulse: `rrat_free_reg` is to be enqueued to the free list.
- `rrat_free_reg`  out  6  physical register being freed.
- `rrat_my_map`  out  [5:0] x 32  committed map (unpacked array, index = arch reg).
- `frat_restore`  out  1  one-cycle pulse: FRAT copies `rrat_my_map`.
- `retire_count`  out  integer  retired-instruction count.
- `rrat_error`  out  1  sticky consistency error (see Configuration).

## Operation
- Reset: `rrat_my_map[i]` = i for all i; `rrat_free`=0, `rrat_free_reg`=0, `frat_restore`=0, `retire_count`=0, `rrat_error`=0.
- Retire (`rob_retire` & !STALL): `retire_count` += 1.
  - `rob_retire_regwr` & arch != 0: old = map[arch]; map[arch] <= phys; free old.
  - `rob_retire_regwr` & arch == 0: map[0] unchanged (stays 0); free `rob_retire_phys` (the allocated tag is never architecturally visible).
  - `rob_retire_regwr` & phys == old mapping: no map change, no free.
  - !`rob_retire_regwr`: no map change, no free.
- Free: at most one per cycle; `rrat_free` high for exactly the cycle after the retiring edge, else 0. `rrat_free_reg` holds last value when `rrat_free`=0.
- STALL: retire ignored (ROB holds head), map and counter frozen, `rrat_free` and `frat_restore` forced 0. A FLUSH during STALL is held pending and issued on the first unstalled edge.
- FLUSH (!STALL): `frat_restore` pulses the following cycle; a retire sampled on the same edge is applied first, so `rrat_my_map` seen with `frat_restore` already includes it, and its free still issues.
- Reset mid-operation clears pending flush, pending free and map immediately (async).

## Timing
- Retire sampled at posedge N → `rrat_my_map`, `rrat_free`, `rrat_free_reg` valid after posedge N; stable before the next negedge, where the rename stage samples.
- Back-to-back retires: one free pulse per cycle, no bubbles.
- Flush latency: 1 cycle (FLUSH at edge N → `frat_restore` high in cycle N..N+1).
- No combinational path from inputs to outputs.

## Configuration
- `RRAT_CHECK_EN` defined: shadow 64-bit "mapped" vector (bit set for every phys currently in `rrat_my_map`); `rrat_error` sets and stays set if a retire installs an already-mapped phys at a different arch reg or frees a phys still mapped elsewhere; clears only on reset.
- Undefined: no shadow vector; `rrat_error` tied 0.

## Structure
- Shared package/`config.v`: `NUM_ARCH`, `NUM_PHYS`, `PREG_W`, arch-reg-0 constant.
- Optional sub-module `rrat_check` (shadow vector + error flag), instantiated only under `RRAT_CHECK_EN`.

## Test plan
- Reset → map[i]=i for i=0..31, all pulses 0, `retire_count`=0.
- Retire regwr arch=5 phys=40 → map[5]=40; next cycle `rrat_free`=1, `rrat_free_reg`=5; `retire_count`=1.
- Retire regwr arch=0 phys=33 → map[0]=0, `rrat_free_reg`=33; retire non-regwr → no free, count increments.
- Three back-to-back retires (arch 3→34, 3→35, 7→36) → frees 3, 34, 7 on consecutive cycles; map[3]=35, map[7]=36.
- STALL held 2 cycles with `rob_retire`=1 and FLUSH=1 → no change, no pulses; on release retire applies, `frat_restore` pulses once with updated map.
- `RRAT_CHECK_EN`: retire arch=4 phys=40 while map[5]=40 → `rrat_error`=1, stays 1 until RESET low.
